// File: rtl/bram_delay_ctrl_if.sv
// Control/status bundle between the delay-line sequencer and its user:
// delay configuration handshake plus the BRAM address/enable side.
interface bram_delay_ctrl_if #(
  parameter int ADDR_BITS = 10
);
  logic                 ce;
  logic [ADDR_BITS:0]   delay_in;
  logic                 delay_ld;
  logic                 delay_ack;
  logic                 delay_err;
  logic [ADDR_BITS:0]   delay_cur;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 wr_en;
  logic                 rd_en;
  logic                 busy;
  logic                 dout_valid;

  modport master (
    output ce, delay_in, delay_ld,
    input  delay_ack, delay_err, delay_cur, wr_addr, rd_addr,
    input  wr_en, rd_en, busy, dout_valid
  );

  modport slave (
    input  ce, delay_in, delay_ld,
    output delay_ack, delay_err, delay_cur, wr_addr, rd_addr,
    output wr_en, rd_en, busy, dout_valid
  );
endinterface

// File: rtl/bram_delay_ctrl.sv
// Address/enable sequencer for a simple-dual-port BRAM delay line with runtime delay.
// Optional macro BRAM_DELAY_CTRL_CLAMP_EN: saturate out-of-range delays instead of rejecting.
//
//   state | meaning
//   FILL  | buffer priming after reset or accepted load; busy=1, dout_valid=0
//   RUN   | buffer primed; BRAM output is input delayed by delay_cur samples
module bram_delay_ctrl #(
  parameter int ADDR_BITS     = 10,
  parameter int LATENCY       = 2,
  parameter int DEFAULT_DELAY = 1024
) (
  input  logic              clk,
  input  logic              rst,
  bram_delay_ctrl_if.slave  bus
);

  localparam int DW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0]   DLY_MIN = DW'(LATENCY + 1);
  localparam logic [ADDR_BITS:0]   DLY_MAX = DW'(2 ** ADDR_BITS);
  localparam logic [ADDR_BITS:0]   DLY_RST = DW'(DEFAULT_DELAY);
  localparam logic [ADDR_BITS:0]   LAT_W   = DW'(LATENCY);
  localparam logic [ADDR_BITS:0]   ONE_W   = DW'(1);
  localparam logic [ADDR_BITS-1:0] ONE_A   = ADDR_BITS'(1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   fill_q, fill_d;
  logic [ADDR_BITS:0]   delay_q, delay_d;
  logic [ADDR_BITS-1:0] wr_ctr_q;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic                 dly_low;
  logic                 dly_high;
  logic                 ld_take;
  logic [ADDR_BITS:0]   dly_eff;

  // Range decode of the requested delay; clamp build turns every load into an accept.
  always_comb begin
    dly_low  = (bus.delay_in < DLY_MIN);
    dly_high = (bus.delay_in > DLY_MAX);
`ifdef BRAM_DELAY_CTRL_CLAMP_EN
    if (dly_low)
      dly_eff = DLY_MIN;
    else if (dly_high)
      dly_eff = DLY_MAX;
    else
      dly_eff = bus.delay_in;
    ld_take = bus.delay_ld;
`else
    dly_eff = bus.delay_in;
    ld_take = bus.delay_ld && !dly_low && !dly_high;
`endif
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    delay_d = delay_q;
    ack_d   = 1'b0;
    err_d   = bus.delay_ld && (dly_low || dly_high);

    if (state_q == FILL && bus.ce) begin
      fill_d = fill_q + ONE_W;
      if (fill_q == delay_q - ONE_W)
        state_d = RUN;
    end

    // An accepted load overrides the FILL->RUN step so priming restarts cleanly.
    if (ld_take) begin
      delay_d = dly_eff;
      ack_d   = 1'b1;
      state_d = FILL;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      fill_q   <= '0;
      delay_q  <= DLY_RST;
      wr_ctr_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      delay_q <= delay_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (bus.ce)
        wr_ctr_q <= wr_ctr_q + ONE_A;
    end
  end

  // Read slot trails the write slot by (delay - latency) so data lands after exactly delay samples.
  assign bus.wr_addr    = wr_ctr_q;
  assign bus.rd_addr    = wr_ctr_q - ADDR_BITS'(delay_q - LAT_W);
  assign bus.wr_en      = bus.ce;
  assign bus.rd_en      = bus.ce;
  assign bus.busy       = (state_q == FILL);
  assign bus.dout_valid = (state_q == RUN);
  assign bus.delay_cur  = delay_q;
  assign bus.delay_ack  = ack_q;
  assign bus.delay_err  = err_q;

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Directed bench for bram_delay_ctrl with a 2-cycle-latency BRAM model carrying a ramp.
`timescale 1ns/1ps
module tb_bram_delay_ctrl;
  localparam int AB = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_delay_ctrl_if #(.ADDR_BITS(AB)) bus ();

  bram_delay_ctrl #(
    .ADDR_BITS(AB),
    .LATENCY(2),
    .DEFAULT_DELAY(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mem [0:1023];
  logic [15:0] ramp, p1, p2;

  always @(posedge clk) begin
    if (rst)
      ramp <= '0;
    else if (bus.wr_en) begin
      mem[bus.wr_addr] <= ramp;
      ramp <= ramp + 16'd1;
    end
    if (bus.rd_en) begin
      p1 <= mem[bus.rd_addr];
      p2 <= p1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [AB:0] d);
    bus.delay_in = d;
    bus.delay_ld = 1'b1;
    @(negedge clk);
    bus.delay_ld = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!bus.dout_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_data(input string tag, input int d);
    logic [15:0] e;
    e = ramp - 16'(d);
    chk({tag, "_valid"}, bus.dout_valid, 1);
    chk(tag, p2, e);
  endtask

  task automatic chk_rd(input string tag, input int off);
    logic [AB-1:0] a;
    a = bus.wr_addr + AB'(off);
    chk(tag, bus.rd_addr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n, c;
    logic ce_now;
    logic [AB-1:0] prev, rexp [0:4];
    logic found;

    rst = 1'b1;
    bus.ce = 1'b0;
    bus.delay_in = '0;
    bus.delay_ld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cur", bus.delay_cur, 1024);
    chk("rst_wr", bus.wr_addr, 0);
    chk("rst_rd", bus.rd_addr, 2);
    chk("rst_busy", bus.busy, 1);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_ack", bus.delay_ack, 0);
    chk("rst_err", bus.delay_err, 0);

    // 1: default delay 1024 priming
    rst = 1'b0;
    bus.ce = 1'b1;
    @(negedge clk);
    chk("t1_wr1", bus.wr_addr, 1);
    chk_rd("t1_rd1", 2);
    chk("t1_busy", bus.busy, 1);
    wait_valid(1200, n);
    chk("t1_fill_len", n + 1, 1024);
    for (int i = 0; i < 6; i++) begin
      chk_data("t1_data", 1024);
      chk_rd("t1_rd", 2);
      chk("t1_busy_run", bus.busy, 0);
      @(negedge clk);
    end

    // 2: switch to 16 while in RUN
    load(16);
    chk("t2_ack", bus.delay_ack, 1);
    chk("t2_cur", bus.delay_cur, 16);
    chk("t2_valid", bus.dout_valid, 0);
    chk("t2_busy", bus.busy, 1);
    chk_rd("t2_rd", 1024 - 14);
    @(negedge clk);
    chk("t2_ack_pulse", bus.delay_ack, 0);
    wait_valid(100, n);
    chk("t2_fill_len", n + 1, 16);
    for (int i = 0; i < 6; i++) begin
      chk_data("t2_data", 16);
      @(negedge clk);
    end

    // 3: ce toggling, load cycle carries ce=1
    load(16);
    chk("t3_ack", bus.delay_ack, 1);
    c = 0;
    while (!bus.dout_valid && c < 100) begin
      c++;
      ce_now = (c % 2 == 0);
      bus.ce = ce_now;
      prev = bus.wr_addr;
      @(negedge clk);
      if (!ce_now && c <= 5)
        chk("t3_wr_hold", bus.wr_addr, prev);
    end
    chk("t3_fill_clks", c, 32);
    chk_data("t3_data", 16);

    // 4: out-of-range requests with ce=0, then minimum legal delay
    bus.ce = 1'b0;
    load(2);
`ifdef BRAM_DELAY_CTRL_CLAMP_EN
    chk("t4_lo_ack", bus.delay_ack, 1);
    chk("t4_lo_err", bus.delay_err, 1);
    chk("t4_lo_cur", bus.delay_cur, 3);
    chk("t4_lo_busy", bus.busy, 1);
`else
    chk("t4_lo_ack", bus.delay_ack, 0);
    chk("t4_lo_err", bus.delay_err, 1);
    chk("t4_lo_cur", bus.delay_cur, 16);
    chk("t4_lo_valid", bus.dout_valid, 1);
`endif
    @(negedge clk);
    chk("t4_err_pulse", bus.delay_err, 0);
    load(1025);
    chk("t4_hi_err", bus.delay_err, 1);
`ifdef BRAM_DELAY_CTRL_CLAMP_EN
    chk("t4_hi_ack", bus.delay_ack, 1);
    chk("t4_hi_cur", bus.delay_cur, 1024);
`else
    chk("t4_hi_ack", bus.delay_ack, 0);
    chk("t4_hi_cur", bus.delay_cur, 16);
`endif
    bus.ce = 1'b1;
    load(3);
    chk("t4_min_ack", bus.delay_ack, 1);
    chk("t4_min_err", bus.delay_err, 0);
    chk("t4_min_cur", bus.delay_cur, 3);
    chk_rd("t4_min_rd", 1023);
    wait_valid(50, n);
    chk("t4_min_fill", n, 3);
    for (int i = 0; i < 4; i++) begin
      chk_data("t4_data", 3);
      @(negedge clk);
    end

    // 5: reset and load together mid-FILL
    load(16);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.delay_in = 16;
    bus.delay_ld = 1'b1;
    @(negedge clk);
    chk("t5_cur", bus.delay_cur, 1024);
    chk("t5_wr", bus.wr_addr, 0);
    chk("t5_busy", bus.busy, 1);
    chk("t5_ack", bus.delay_ack, 0);
    chk("t5_valid", bus.dout_valid, 0);
    rst = 1'b0;
    bus.delay_ld = 1'b0;

    // 6: delay 5 across the address wrap
    load(5);
    wait_valid(50, n);
    chk("t6_fill", n, 5);
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      if (bus.wr_addr == 10'd1023)
        found = 1'b1;
      else
        @(negedge clk);
    end
    chk("t6_reach", found, 1);
    rexp[0] = 10'd1020; rexp[1] = 10'd1021; rexp[2] = 10'd1022;
    rexp[3] = 10'd1023; rexp[4] = 10'd0;
    for (int i = 0; i < 5; i++) begin
      chk("t6_rd", bus.rd_addr, rexp[i]);
      chk_data("t6_data", 5);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
